// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl
//   Byte-serial controller for the 8-bit unified memory port. It serves two
//   clients. The ICache gets line fills of LINE_BYTES bytes. The LSB gets
//   1/2/4-byte loads and stores at any alignment.
//   The RAM is synchronous: mem_din returns the byte for the address that
//   was on mem_a during the previous cycle. A read of N bytes therefore
//   finishes N+1 cycles after the request is accepted.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   rdy             global enable; low freezes every register and blocks writes
//   mem_din         RAM read data (one cycle after its address)
//   mem_dout/mem_a  RAM write data / byte address (registered)
//   mem_wr          RAM write strobe
//   io_buffer_full  write back-pressure; a store byte is issued only when low
//   flush           aborts an ICache fill in flight
//   if_req/if_addr  ICache fill request and start address
//   if_done/if_data fill complete pulse and line data (byte k at [8k+7:8k])
//   ls_req/ls_wr/ls_size/ls_signed/ls_addr/ls_wdata  LSB access request
//   ls_done/ls_rdata  access complete pulse and extended load data
module mem_burst_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [ADDR_W-1:0]       mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full,
  input  logic                    flush,
  input  logic                    if_req,
  input  logic [ADDR_W-1:0]       if_addr,
  output logic                    if_done,
  output logic [LINE_BYTES*8-1:0] if_data,
  input  logic                    ls_req,
  input  logic                    ls_wr,
  input  logic [1:0]              ls_size,
  input  logic                    ls_signed,
  input  logic [ADDR_W-1:0]       ls_addr,
  input  logic [31:0]             ls_wdata,
  output logic                    ls_done,
  output logic [31:0]             ls_rdata
);

  // cnt must reach LINE_BYTES+1 during a fill (one extra cycle for RAM latency)
  localparam int CNT_W = $clog2(LINE_BYTES) + 1;

  typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                mem_wr_q;

  // Transaction context, loaded on accept; no reset needed
  logic [ADDR_W-1:0]   start_addr;
  logic [CNT_W-1:0]    n_bytes;
  logic [1:0]          size_r;
  logic                signed_r;
  logic [31:0]         wdata_r;
  logic [31:0]         ls_buf;

  logic                idle_open;
  logic                accept_ls;
  logic                accept_if;
  logic [ADDR_W-1:0]   addr_next;
  logic [1:0]          cap_byte;
  logic [1:0]          wr_byte;
  logic [31:0]         ls_buf_next;

  function automatic logic [CNT_W-1:0] size_to_bytes(input logic [1:0] size);
    case (size)
      2'd0:    return CNT_W'(1);
      2'd1:    return CNT_W'(2);
      default: return CNT_W'(4);
    endcase
  endfunction

  // Sign- or zero-extend the assembled load bytes. A word ignores ls_signed.
  function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                              input logic [1:0]  size,
                                              input logic        sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] sx;
    b  = raw[7:0];
    h  = raw[15:0];
    sx = 32'sd0;
    case (size)
      2'd0: begin
        sx = b;
        return sgn ? 32'(sx) : {24'd0, raw[7:0]};
      end
      2'd1: begin
        sx = h;
        return sgn ? 32'(sx) : {16'd0, raw[15:0]};
      end
      default: return raw;
    endcase
  endfunction

  // The cycle carrying a done pulse is a dead cycle for new requests
  assign idle_open = (state == IDLE) && !if_done && !ls_done;
  assign accept_ls = idle_open && ls_req;
  assign accept_if = idle_open && !ls_req && if_req && !flush;

  assign addr_next = start_addr + ADDR_W'(cnt);
  assign wr_byte   = cnt[1:0];
  // At count c, mem_din holds the byte addressed two steps earlier
  assign cap_byte  = 2'(cnt - CNT_W'(2));

  always_comb begin
    ls_buf_next = ls_buf;
    ls_buf_next[{cap_byte, 3'b000} +: 8] = mem_din;
  end

  // A stalled rdy must never let a registered strobe reach the RAM
  assign mem_wr = mem_wr_q & rdy;

  // Control, address/data port and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      mem_a    <= '0;
      mem_dout <= '0;
      mem_wr_q <= 1'b0;
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      if_data  <= '0;
      ls_rdata <= '0;
    end else if (rdy) begin
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      mem_wr_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_ls) begin
            if (ls_wr) begin
              state <= LS_WR;
              if (!io_buffer_full) begin
                mem_a    <= ls_addr;
                mem_dout <= ls_wdata[7:0];
                mem_wr_q <= 1'b1;
                cnt      <= CNT_W'(1);
              end else begin
                cnt      <= '0;
              end
            end else begin
              state <= LS_RD;
              mem_a <= ls_addr;
              cnt   <= CNT_W'(1);
            end
          end else if (accept_if) begin
            state <= IF_RD;
            mem_a <= if_addr;
            cnt   <= CNT_W'(1);
          end
        end

        // cnt = number of addresses issued so far (until it passes n_bytes);
        // capture starts at cnt == 2 and the last byte lands at n_bytes+1.
        IF_RD, LS_RD: begin
          if (state == IF_RD && flush) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            if (cnt < n_bytes) begin
              mem_a <= addr_next;
            end
            if (cnt >= CNT_W'(2) && state == IF_RD) begin
              if_data <= {mem_din, if_data[LINE_BYTES*8-1:8]};
            end
            if (cnt == n_bytes + CNT_W'(1)) begin
              state <= IDLE;
              cnt   <= '0;
              if (state == IF_RD) begin
                if_done <= 1'b1;
              end else begin
                ls_done  <= 1'b1;
                ls_rdata <= extend_load(ls_buf_next, size_r, signed_r);
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        // Each edge with io_buffer_full high leaves cnt alone and issues nothing
        LS_WR: begin
          if (cnt == n_bytes) begin
            state   <= IDLE;
            cnt     <= '0;
            ls_done <= 1'b1;
          end else if (!io_buffer_full) begin
            mem_a    <= addr_next;
            mem_dout <= wdata_r[{wr_byte, 3'b000} +: 8];
            mem_wr_q <= 1'b1;
            cnt      <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Transaction context and load assembly buffer
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (accept_ls) begin
        start_addr <= ls_addr;
        n_bytes    <= size_to_bytes(ls_size);
        size_r     <= ls_size;
        signed_r   <= ls_signed;
        wdata_r    <= ls_wdata;
      end else if (accept_if) begin
        start_addr <= if_addr;
        n_bytes    <= CNT_W'(LINE_BYTES);
      end
      if (state == LS_RD && cnt >= CNT_W'(2)) begin
        ls_buf <= ls_buf_next;
      end
    end
  end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
module tb_mem_burst_ctrl;

  localparam int AW = 32;
  localparam int LB = 16;

  logic            clk;
  logic            rst;
  logic            rdy;
  logic [7:0]      mem_din;
  logic [7:0]      mem_dout;
  logic [AW-1:0]   mem_a;
  logic            mem_wr;
  logic            io_buffer_full;
  logic            flush;
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_done;
  logic [LB*8-1:0] if_data;
  logic            ls_req;
  logic            ls_wr;
  logic [1:0]      ls_size;
  logic            ls_signed;
  logic [AW-1:0]   ls_addr;
  logic [31:0]     ls_wdata;
  logic            ls_done;
  logic [31:0]     ls_rdata;

  mem_burst_ctrl #(.ADDR_W(AW), .LINE_BYTES(LB)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_signed(ls_signed),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous 64 KiB RAM (address aliased on the low 16 bits)
  logic [7:0] ram [0:65535];
  always @(posedge clk) begin
    if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
    mem_din <= ram[mem_a[15:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pat(input logic [31:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h3C;
  endfunction

  typedef struct { logic [31:0] data; bit chk; int t0; int lat; } ls_exp_t;
  typedef struct { logic [LB*8-1:0] data; int t0; int lat; } if_exp_t;
  typedef struct { logic [31:0] addr; logic [7:0] data; } wr_exp_t;

  ls_exp_t ls_q[$];
  if_exp_t if_q[$];
  wr_exp_t wr_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result or a write
  ls_exp_t le;
  if_exp_t fe;
  wr_exp_t we;
  always @(negedge clk) begin
    if (!rst && rdy) begin
      if (ls_done) begin
        if (ls_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ls_done_unexpected: got ls_done=1 expected none at cycle %0d", cyc);
        end else begin
          le = ls_q.pop_front();
          if (le.chk) check("ls_rdata", 128'(ls_rdata), 128'(le.data));
          check("ls_latency", 128'(cyc - le.t0), 128'(le.lat));
        end
      end
      if (if_done) begin
        if (if_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL if_done_unexpected: got if_done=1 expected none at cycle %0d", cyc);
        end else begin
          fe = if_q.pop_front();
          check("if_data", if_data, fe.data);
          check("if_latency", 128'(cyc - fe.t0), 128'(fe.lat));
        end
      end
      if (mem_wr) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL write_unexpected: got write %h@%h expected none", mem_dout, mem_a);
        end else begin
          we = wr_q.pop_front();
          check("wr_addr", 128'(mem_a), 128'(we.addr));
          check("wr_data", 128'(mem_dout), 128'(we.data));
        end
      end
    end
  end

  task automatic push_wr(input logic [31:0] a, input logic [7:0] d);
    wr_exp_t w;
    w.addr = a; w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic ls_op(input bit wr, input logic [1:0] size, input bit sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_data, input int lat);
    ls_exp_t e;
    int n;
    @(posedge clk); #1;
    ls_wr = wr; ls_size = size; ls_signed = sgn; ls_addr = addr; ls_wdata = wdata;
    ls_req = 1'b1;
    e.data = exp_data; e.chk = !wr; e.t0 = cyc + 1; e.lat = lat;
    ls_q.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (!ls_done && n < 300);
    check("ls_done_seen", 128'(ls_done), 128'(1));
    ls_req = 1'b0;
  endtask

  task automatic if_op(input logic [31:0] addr, input int lat);
    if_exp_t e;
    int n;
    @(posedge clk); #1;
    if_addr = addr; if_req = 1'b1;
    for (int k = 0; k < LB; k++) e.data[8*k +: 8] = pat(addr + 32'(k));
    e.t0 = cyc + 1; e.lat = lat;
    if_q.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (!if_done && n < 300);
    check("if_done_seen", 128'(if_done), 128'(1));
    if_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_a"},    128'(mem_a),    128'(0));
    check({tag, "_mem_dout"}, 128'(mem_dout), 128'(0));
    check({tag, "_mem_wr"},   128'(mem_wr),   128'(0));
    check({tag, "_if_done"},  128'(if_done),  128'(0));
    check({tag, "_ls_done"},  128'(ls_done),  128'(0));
    check({tag, "_if_data"},  if_data,        128'(0));
    check({tag, "_ls_rdata"}, 128'(ls_rdata), 128'(0));
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] <= pat(32'(i));
    ram[16'h1001] <= 8'h11; ram[16'h1002] <= 8'h22;
    ram[16'h1003] <= 8'h33; ram[16'h1004] <= 8'h84;
    ram[16'h2000] <= 8'h80;
    ram[16'h2010] <= 8'h80; ram[16'h2011] <= 8'hFF;
    ram[16'h2020] <= 8'h34; ram[16'h2021] <= 8'h12;
    ram[16'hFFFE] <= 8'h01; ram[16'hFFFF] <= 8'h02;

    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; flush = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_wr = 1'b0; ls_size = 2'd0; ls_signed = 1'b0;
    ls_addr = '0; ls_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Loads: word at odd address, signed/unsigned byte and half
    ls_op(0, 2'd2, 0, 32'h0000_1001, 32'h0, 32'h8433_2211, 5);
    ls_op(0, 2'd0, 1, 32'h0000_2000, 32'h0, 32'hFFFF_FF80, 2);
    ls_op(0, 2'd0, 0, 32'h0000_2000, 32'h0, 32'h0000_0080, 2);
    ls_op(0, 2'd1, 0, 32'h0000_2010, 32'h0, 32'h0000_FF80, 3);
    ls_op(0, 2'd1, 1, 32'h0000_2010, 32'h0, 32'hFFFF_FF80, 3);
    ls_op(0, 2'd1, 1, 32'h0000_2020, 32'h0, 32'h0000_1234, 3);

    // SW with io_buffer_full seen at the 2nd and 3rd edges
    push_wr(32'h0003_0000, 8'hEF); push_wr(32'h0003_0001, 8'hBE);
    push_wr(32'h0003_0002, 8'hAD); push_wr(32'h0003_0003, 8'hDE);
    fork
      ls_op(1, 2'd2, 0, 32'h0003_0000, 32'hDEAD_BEEF, 32'h0, 6);
      begin
        @(posedge clk);
        @(posedge clk); #1 io_buffer_full = 1'b1;
        @(posedge clk);
        @(negedge clk); check("wr_blocked_full_1", 128'(mem_wr), 128'(0));
        @(posedge clk); #1 io_buffer_full = 1'b0;
        @(negedge clk); check("wr_blocked_full_2", 128'(mem_wr), 128'(0));
      end
    join
    ls_op(0, 2'd2, 0, 32'h0003_0000, 32'h0, 32'hDEAD_BEEF, 5);
    // Address wrap: FFFFFFFE, FFFFFFFF, 0, 1
    ls_op(0, 2'd3, 1, 32'hFFFF_FFFE, 32'h0, 32'hBEEF_0201, 5);

    // Byte and half stores
    push_wr(32'h0004_0007, 8'hA5);
    ls_op(1, 2'd0, 0, 32'h0004_0007, 32'h0000_00A5, 32'h0, 1);
    push_wr(32'h0004_0010, 8'h78); push_wr(32'h0004_0011, 8'h56);
    ls_op(1, 2'd1, 0, 32'h0004_0010, 32'h1234_5678, 32'h0, 2);

    // Simultaneous requests: LSB first, fill accepted after the dead cycle
    fork
      ls_op(0, 2'd2, 0, 32'h0000_1001, 32'h0, 32'h8433_2211, 5);
      if_op(32'h0000_0500, 24);
    join

    // Flush during fill byte 5
    @(posedge clk); #1 if_addr = 32'h0000_0100; if_req = 1'b1;
    repeat (5) @(posedge clk);
    #1 flush = 1'b1; if_req = 1'b0;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_no_done", 128'(if_done), 128'(0));
    repeat (3) @(negedge clk);
    check("flush_mem_a_hold", 128'(mem_a), 128'(32'h0000_0104));
    check("flush_no_write", 128'(mem_wr), 128'(0));
    if_op(32'h0000_0200, 17);

    // rdy low for three cycles in the middle of a SW
    push_wr(32'h0004_0020, 8'h0D); push_wr(32'h0004_0021, 8'hF0);
    push_wr(32'h0004_0022, 8'hFE); push_wr(32'h0004_0023, 8'hCA);
    fork
      ls_op(1, 2'd2, 0, 32'h0004_0020, 32'hCAFE_F00D, 32'h0, 7);
      begin
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1 rdy = 1'b0;
        @(negedge clk); check("rdy_low_no_write", 128'(mem_wr), 128'(0));
        repeat (3) @(posedge clk);
        #1 rdy = 1'b1;
      end
    join

    // Reset in the middle of a fill
    @(posedge clk); #1 if_addr = 32'h0000_0300; if_req = 1'b1;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1; if_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    repeat (20) @(negedge clk);
    check("midrst_idle_mem_a", 128'(mem_a), 128'(0));

    check("ls_queue_drained", 128'(ls_q.size()), 128'(0));
    check("if_queue_drained", 128'(if_q.size()), 128'(0));
    check("wr_queue_drained", 128'(wr_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
